vending_machine_param: RTL and testbench
========================================

Name: vending_machine_param

Overview:
Parametrised coin-operated vending controller. It accumulates credit from four coin inputs (nickel, dime, quarter, dollar) and vends one item when credit reaches PRICE. It then returns change serially, one coin per cycle, using quarters, dimes and nickels. It supports cancel/refund and rejects coins that are illegal or would overflow the credit register. It sits between the coin acceptor front-end and the dispense/coin-return actuators.

Parameters:
PRICE, 75, item price in cents; multiple of 5; 5 <= PRICE <= MAX_CREDIT
MAX_CREDIT, 200, highest credit accepted in cents; multiple of 5; must be < 2**CREDIT_W
CREDIT_W, 8, width of the credit register and the credit output

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
n_in  in  1  nickel inserted (5), one-cycle pulse
dm_in  in  1  dime inserted (10), one-cycle pulse
q_in  in  1  quarter inserted (25), one-cycle pulse
d_in  in  1  dollar inserted (100), one-cycle pulse
cancel  in  1  refund request, one-cycle pulse
dispense  out  1  vend item, one-cycle pulse
chg_q  out  1  eject one quarter
chg_d  out  1  eject one dime
chg_n  out  1  eject one nickel
coin_rej  out  1  inserted coin returned uncredited, one-cycle pulse
busy  out  1  vend or change in progress; coins are rejected while high
credit  out  CREDIT_W  current credit in cents

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst.
- Reset forces: state IDLE, credit 0, coin_rej 0. All other outputs decode to 0.
- States:
  - IDLE: credit == 0.
  - COLLECT: 0 < credit < PRICE.
  - VEND.
  - CHANGE.
- Coin valid = exactly one of n_in/dm_in/q_in/d_in high at the edge.
- Two or more coin inputs high at once: all are rejected. coin_rej is 1 for the next cycle; credit is unchanged.
- IDLE/COLLECT, valid coin:
  - If credit + value > MAX_CREDIT: reject (coin_rej pulse), credit unchanged.
  - Otherwise credit <= credit + value.
  - If the new credit >= PRICE, go to VEND; else go to COLLECT.
- Overflow arithmetic: the sum is computed CREDIT_W+1 bits wide, so a sum that wraps still counts as overflow.
- cancel in COLLECT:
  - Go to CHANGE with credit unchanged (full refund).
  - cancel has priority over a coin in the same cycle; that coin is rejected.
- cancel in IDLE, VEND or CHANGE is ignored.
- VEND, one cycle:
  - dispense = 1 (Moore decode).
  - At the edge, credit <= credit - PRICE.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE, one coin per cycle, Moore decode of the registered credit:
  - credit >= 25: chg_q = 1, credit -= 25.
  - else credit >= 10: chg_d = 1, credit -= 10.
  - else: chg_n = 1, credit -= 5.
  - Next state is IDLE when the new credit is 0.
- At most one chg_* output is high in any cycle.
- busy = (state == VEND or state == CHANGE).
- Any coin arriving while busy is rejected with a coin_rej pulse and is never credited.
- Latency:
  - Coin at edge N: credit is visible after edge N.
  - If credit reaches PRICE: dispense is high in the cycle after edge N.
  - The first change coin appears the following cycle.
- coin_rej is a registered pulse, high exactly one cycle per rejecting edge. Back-to-back rejects give back-to-back pulses.
- Reset asserted mid-VEND or mid-CHANGE: outputs drop immediately. Remaining change is forfeited and credit reads 0.
- Elaboration check: violating the parameter constraints is a fatal error.

Optional Feature:
Macro: VM_SALES_CNT_EN
- Defined: adds output port sales_cnt [15:0]. It increments by 1 at every edge leaving VEND, saturates at 16'hFFFF, and resets to 0.
- Undefined: no sales_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Defaults; reset, then q_in in 3 consecutive cycles -> credit 25, 50, 75; dispense 1 for one cycle; no chg_*; IDLE with credit 0 the next cycle.
- Defaults; single d_in -> credit 100; dispense one cycle; then chg_q one cycle; credit 0; busy high for exactly 2 cycles.
- Defaults; n_in, then dm_in (credit 15), then cancel together with q_in -> coin_rej 1; then chg_d one cycle, chg_n one cycle; credit 0; dispense never asserted.
- Defaults; dm_in and q_in in the same cycle -> coin_rej one cycle, credit stays 0. Then q_in followed by d_in (125) -> dispense; change 50 as chg_q, chg_q. A q_in issued during CHANGE -> coin_rej, credit unaffected.
- MAX_CREDIT=100, PRICE=75; q_in, q_in (credit 50), then d_in -> coin_rej, credit stays 50, state COLLECT.
- Defaults; d_in, then assert rst during the chg_q cycle -> chg_q, dispense and busy drop asynchronously; credit 0. After release, q_in x3 vends normally. With VM_SALES_CNT_EN, sales_cnt is 0 after reset and 1 after the vend.

Source files
------------

// File: rtl/vending_machine_param.sv
// Coin-operated vending controller: accumulates credit, vends at PRICE, returns change serially.
// Optional sales counter output enabled by defining VM_SALES_CNT_EN.
module vending_machine_param #(
  parameter int PRICE      = 75,
  parameter int MAX_CREDIT = 200,
  parameter int CREDIT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                n_in,
  input  logic                dm_in,
  input  logic                q_in,
  input  logic                d_in,
  input  logic                cancel,
  output logic                dispense,
  output logic                chg_q,
  output logic                chg_d,
  output logic                chg_n,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
`ifdef VM_SALES_CNT_EN
  ,
  output logic [15:0]         sales_cnt
`endif
);

  // state   | meaning
  // IDLE    | no credit, waiting for first coin
  // COLLECT | 0 < credit < PRICE
  // VEND    | dispense pulse, price deducted at the edge
  // CHANGE  | one change coin per cycle until credit is 0
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  // Arithmetic width is at least CREDIT_W+1 and wide enough to hold a dollar.
  localparam int SUM_W = (CREDIT_W + 1 > 8) ? CREDIT_W + 1 : 8;
  localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0] MAX_S   = SUM_W'(MAX_CREDIT);
  localparam logic [SUM_W-1:0] V_N     = SUM_W'(5);
  localparam logic [SUM_W-1:0] V_DM    = SUM_W'(10);
  localparam logic [SUM_W-1:0] V_Q     = SUM_W'(25);
  localparam logic [SUM_W-1:0] V_D     = SUM_W'(100);

  if ((PRICE % 5) != 0 || PRICE < 5 || PRICE > MAX_CREDIT ||
      (MAX_CREDIT % 5) != 0 || MAX_CREDIT >= (2 ** CREDIT_W)) begin : g_param_check
    $fatal(1, "vending_machine_param: illegal PRICE/MAX_CREDIT/CREDIT_W combination");
  end

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  coin_rej_q, coin_rej_d;

  logic [2:0]            n_coins;
  logic                  any_coin, one_coin;
  logic [SUM_W-1:0]      coin_val, credit_s, sum, chg_amt, remain;

  assign n_coins  = {2'b00, n_in} + {2'b00, dm_in} + {2'b00, q_in} + {2'b00, d_in};
  assign any_coin = (n_coins != 3'd0);
  assign one_coin = (n_coins == 3'd1);
  assign credit_s = SUM_W'(credit_q);
  assign sum      = credit_s + coin_val;

  always_comb begin
    coin_val = '0;
    if (n_in)       coin_val = V_N;
    else if (dm_in) coin_val = V_DM;
    else if (q_in)  coin_val = V_Q;
    else if (d_in)  coin_val = V_D;
  end

  always_comb begin
    chg_amt = V_N;
    if (credit_s >= V_Q)       chg_amt = V_Q;
    else if (credit_s >= V_DM) chg_amt = V_DM;
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    coin_rej_d = 1'b0;
    remain     = '0;
    case (state_q)
      IDLE, COLLECT: begin
        if (state_q == COLLECT && cancel) begin
          state_d    = CHANGE;
          coin_rej_d = any_coin;
        end else if (any_coin && !one_coin) begin
          coin_rej_d = 1'b1;
        end else if (one_coin) begin
          if (sum > MAX_S) begin
            coin_rej_d = 1'b1;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = (sum >= PRICE_S) ? VEND : COLLECT;
          end
        end
      end
      VEND: begin
        coin_rej_d = any_coin;
        remain     = credit_s - PRICE_S;
        credit_d   = remain[CREDIT_W-1:0];
        state_d    = (remain != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_rej_d = any_coin;
        if (credit_s <= chg_amt) begin
          credit_d = '0;
          state_d  = IDLE;
        end else begin
          remain   = credit_s - chg_amt;
          credit_d = remain[CREDIT_W-1:0];
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      coin_rej_q <= coin_rej_d;
    end
  end

  assign dispense = (state_q == VEND);
  assign busy     = (state_q == VEND) || (state_q == CHANGE);
  assign chg_q    = (state_q == CHANGE) && (credit_s >= V_Q);
  assign chg_d    = (state_q == CHANGE) && (credit_s < V_Q) && (credit_s >= V_DM);
  assign chg_n    = (state_q == CHANGE) && (credit_s < V_DM);
  assign coin_rej = coin_rej_q;
  assign credit   = credit_q;

`ifdef VM_SALES_CNT_EN
  logic [15:0] sales_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     sales_q <= '0;
    else if (state_q == VEND && sales_q != 16'hFFFF) sales_q <= sales_q + 16'd1;
  end

  assign sales_cnt = sales_q;
`endif

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: default instance plus a MAX_CREDIT=100 instance.
module tb_vending_machine_param;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic a_n = 0, a_dm = 0, a_q = 0, a_d = 0, a_cx = 0;
  logic a_disp, a_cq, a_cd, a_cn, a_rej, a_busy;
  logic [7:0] a_cred;

  logic b_n = 0, b_dm = 0, b_q = 0, b_d = 0, b_cx = 0;
  logic b_disp, b_cq, b_cd, b_cn, b_rej, b_busy;
  logic [7:0] b_cred;

`ifdef VM_SALES_CNT_EN
  logic [15:0] a_sales, b_sales;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  vending_machine_param u_dflt (
    .clk(clk), .rst(rst),
    .n_in(a_n), .dm_in(a_dm), .q_in(a_q), .d_in(a_d), .cancel(a_cx),
    .dispense(a_disp), .chg_q(a_cq), .chg_d(a_cd), .chg_n(a_cn),
    .coin_rej(a_rej), .busy(a_busy), .credit(a_cred)
`ifdef VM_SALES_CNT_EN
    , .sales_cnt(a_sales)
`endif
  );

  vending_machine_param #(.PRICE(75), .MAX_CREDIT(100), .CREDIT_W(8)) u_small (
    .clk(clk), .rst(rst),
    .n_in(b_n), .dm_in(b_dm), .q_in(b_q), .d_in(b_d), .cancel(b_cx),
    .dispense(b_disp), .chg_q(b_cq), .chg_d(b_cd), .chg_n(b_cn),
    .coin_rej(b_rej), .busy(b_busy), .credit(b_cred)
`ifdef VM_SALES_CNT_EN
    , .sales_cnt(b_sales)
`endif
  );

  // in  = {n, dm, q, d, cancel}; out = {dispense, chg_q, chg_d, chg_n, coin_rej, busy}
  typedef struct {
    bit       inst;
    bit [4:0] in;
    bit [5:0] out;
    int       cred;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mv(bit inst, bit [4:0] in, bit [5:0] out, int cred);
    vec_t v;
    v.inst = inst;
    v.in   = in;
    v.out  = out;
    v.cred = cred;
    return v;
  endfunction

  task automatic chk(string nm, int idx, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %0d, want %0d", nm, idx, got, exp);
    end
  endtask

  task automatic chk_a(string nm, bit [5:0] out, int cred);
    chk({nm, ".outs"}, 0, int'({a_disp, a_cq, a_cd, a_cn, a_rej, a_busy}), int'(out));
    chk({nm, ".credit"}, 0, int'(a_cred), cred);
  endtask

  task automatic drive_a(bit [4:0] in);
    {a_n, a_dm, a_q, a_d, a_cx} = in;
  endtask

  initial begin
    // default instance: three quarters vend exactly
    vecs.push_back(mv(0, 5'b00100, 6'b000000,  25));
    vecs.push_back(mv(0, 5'b00100, 6'b000000,  50));
    vecs.push_back(mv(0, 5'b00100, 6'b100001,  75));
    vecs.push_back(mv(0, 5'b00000, 6'b000000,   0));
    // dollar: vend then one quarter of change
    vecs.push_back(mv(0, 5'b00010, 6'b100001, 100));
    vecs.push_back(mv(0, 5'b00000, 6'b010001,  25));
    vecs.push_back(mv(0, 5'b00000, 6'b000000,   0));
    // nickel, dime, cancel+quarter -> refund dime, nickel
    vecs.push_back(mv(0, 5'b10000, 6'b000000,   5));
    vecs.push_back(mv(0, 5'b01000, 6'b000000,  15));
    vecs.push_back(mv(0, 5'b00101, 6'b001011,  15));
    vecs.push_back(mv(0, 5'b00000, 6'b000101,   5));
    vecs.push_back(mv(0, 5'b00000, 6'b000000,   0));
    // double coin, then 125 -> change 50, coin during CHANGE rejected
    vecs.push_back(mv(0, 5'b01100, 6'b000010,   0));
    vecs.push_back(mv(0, 5'b00100, 6'b000000,  25));
    vecs.push_back(mv(0, 5'b00010, 6'b100001, 125));
    vecs.push_back(mv(0, 5'b00000, 6'b010001,  50));
    vecs.push_back(mv(0, 5'b00100, 6'b010011,  25));
    vecs.push_back(mv(0, 5'b00000, 6'b000000,   0));
    // coin during VEND rejected
    vecs.push_back(mv(0, 5'b00010, 6'b100001, 100));
    vecs.push_back(mv(0, 5'b10000, 6'b010011,  25));
    vecs.push_back(mv(0, 5'b00000, 6'b000000,   0));
    // cancel ignored in IDLE, coin with it accepted; cancel in COLLECT refunds
    vecs.push_back(mv(0, 5'b00001, 6'b000000,   0));
    vecs.push_back(mv(0, 5'b10001, 6'b000000,   5));
    vecs.push_back(mv(0, 5'b00001, 6'b000101,   5));
    vecs.push_back(mv(0, 5'b00000, 6'b000000,   0));
    // MAX_CREDIT=100 instance: dollar on top of 50 overflows
    vecs.push_back(mv(1, 5'b00100, 6'b000000,  25));
    vecs.push_back(mv(1, 5'b00100, 6'b000000,  50));
    vecs.push_back(mv(1, 5'b00010, 6'b000010,  50));
    vecs.push_back(mv(1, 5'b00000, 6'b000000,  50));
    vecs.push_back(mv(1, 5'b00001, 6'b010001,  50));
    vecs.push_back(mv(1, 5'b00000, 6'b010001,  25));
    vecs.push_back(mv(1, 5'b00000, 6'b000000,   0));

    #12;
    chk("rst.outs_a", 0, int'({a_disp, a_cq, a_cd, a_cn, a_rej, a_busy}), 0);
    chk("rst.credit_a", 0, int'(a_cred), 0);
    chk("rst.outs_b", 0, int'({b_disp, b_cq, b_cd, b_cn, b_rej, b_busy}), 0);
`ifdef VM_SALES_CNT_EN
    chk("rst.sales", 0, int'(a_sales), 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].inst == 1'b0) {a_n, a_dm, a_q, a_d, a_cx} = vecs[i].in;
      else                      {b_n, b_dm, b_q, b_d, b_cx} = vecs[i].in;
      @(posedge clk);
      #1;
      if (vecs[i].inst == 1'b0) begin
        chk("vec.outs", i, int'({a_disp, a_cq, a_cd, a_cn, a_rej, a_busy}), int'(vecs[i].out));
        chk("vec.credit", i, int'(a_cred), vecs[i].cred);
      end else begin
        chk("vec.outs", i, int'({b_disp, b_cq, b_cd, b_cn, b_rej, b_busy}), int'(vecs[i].out));
        chk("vec.credit", i, int'(b_cred), vecs[i].cred);
      end
      {a_n, a_dm, a_q, a_d, a_cx} = 5'b0;
      {b_n, b_dm, b_q, b_d, b_cx} = 5'b0;
    end

    // back-to-back rejects: two double-coin edges give two adjacent pulses
    @(negedge clk); drive_a(5'b11000);
    @(posedge clk); #1; chk_a("b2b.1", 6'b000010, 0);
    @(negedge clk); drive_a(5'b00110);
    @(posedge clk); #1; chk_a("b2b.2", 6'b000010, 0);
    @(negedge clk); drive_a(5'b00000);
    @(posedge clk); #1; chk_a("b2b.3", 6'b000000, 0);

    // reset asserted during the change cycle forfeits the change
    @(negedge clk); drive_a(5'b00010);
    @(posedge clk); #1; chk_a("rmid.vend", 6'b100001, 100);
    @(negedge clk); drive_a(5'b00000);
    @(posedge clk); #1; chk_a("rmid.chg", 6'b010001, 25);
    #2 rst = 1'b0;
    #1; chk_a("rmid.rst", 6'b000000, 0);
`ifdef VM_SALES_CNT_EN
    chk("rmid.sales", 0, int'(a_sales), 0);
`endif
    @(negedge clk); rst = 1'b1;

    @(negedge clk); drive_a(5'b00100);
    @(posedge clk); #1; chk_a("post.q1", 6'b000000, 25);
    @(negedge clk);
    @(posedge clk); #1; chk_a("post.q2", 6'b000000, 50);
    @(negedge clk);
    @(posedge clk); #1; chk_a("post.q3", 6'b100001, 75);
    @(negedge clk); drive_a(5'b00000);
    @(posedge clk); #1; chk_a("post.idle", 6'b000000, 0);
`ifdef VM_SALES_CNT_EN
    chk("post.sales", 0, int'(a_sales), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
